// File: rtl/golomb_rice_decode_if.sv
// +--------------------------------------------------------------------------+
// | golomb_rice_decode_if : command, bit-stream and result bundle             |
// | Optional decode_err signal when GOLOMB_RICE_DECODE_ERR_EN is defined.      |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface golomb_rice_decode_if #(
  parameter int VAL_W = 32
);
  logic             start;
  logic [2:0]       k;
  logic             is_ac_level;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             output_valid;
  logic [VAL_W-1:0] val;
  logic             is_minus_n;
  logic [VAL_W-1:0] codeword_length;
`ifdef GOLOMB_RICE_DECODE_ERR_EN
  logic             decode_err;

  modport master (
    output start, k, is_ac_level, bit_in, bit_valid,
    input  bit_ready, busy, output_valid, val, is_minus_n, codeword_length, decode_err
  );
  modport slave (
    input  start, k, is_ac_level, bit_in, bit_valid,
    output bit_ready, busy, output_valid, val, is_minus_n, codeword_length, decode_err
  );
`else
  modport master (
    output start, k, is_ac_level, bit_in, bit_valid,
    input  bit_ready, busy, output_valid, val, is_minus_n, codeword_length
  );
  modport slave (
    input  start, k, is_ac_level, bit_in, bit_valid,
    output bit_ready, busy, output_valid, val, is_minus_n, codeword_length
  );
`endif
endinterface

`default_nettype wire

// File: rtl/golomb_rice_decode.sv
// +--------------------------------------------------------------------------+
// | golomb_rice_decode : bit-serial Golomb-Rice decoder, MSB first            |
// | Macro GOLOMB_RICE_DECODE_ERR_EN: flag prefix overflow instead of saturate. |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module golomb_rice_decode #(
  parameter int MAX_Q = 31,
  parameter int VAL_W = 32
) (
  input  wire                    clk,
  input  wire                    reset_n,
  golomb_rice_decode_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFIX = 3'd1,
    S_SUFFIX = 3'd2,
    S_SIGN   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic             ac_q, ac_d;
  logic [4:0]       q_q, q_d;
  logic [6:0]       rem_q, rem_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [VAL_W-1:0] len_q, len_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [VAL_W-1:0] codeword_length_q, codeword_length_d;
  logic             is_minus_n_q, is_minus_n_d;
  logic             decode_err_q, decode_err_d;

  logic             w_busy;
  logic             w_xfer;
  logic             w_done_entry;
  logic             w_err_entry;
  logic             w_sign_bit;

  // Handshake is decoded from registered state only; no path from bit_valid.
  assign w_busy = (state_q == S_PREFIX) || (state_q == S_SUFFIX) || (state_q == S_SIGN);
  assign w_xfer = w_busy && bus.bit_valid;

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    ac_d              = ac_q;
    q_d               = q_q;
    rem_d             = rem_q;
    cnt_d             = cnt_q;
    len_d             = len_q;
    val_d             = val_q;
    codeword_length_d = codeword_length_q;
    is_minus_n_d      = is_minus_n_q;
    decode_err_d      = decode_err_q;
    w_done_entry      = 1'b0;
    w_err_entry       = 1'b0;
    w_sign_bit        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          k_d          = bus.k;
          ac_d         = bus.is_ac_level;
          q_d          = '0;
          rem_d        = '0;
          cnt_d        = '0;
          len_d        = '0;
          decode_err_d = 1'b0;
          state_d      = S_PREFIX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREFIX: begin
        if (w_xfer) begin
          len_d = len_q + VAL_W'(1);
          if (!bus.bit_in) begin
            if (q_q == 5'(MAX_Q)) begin
`ifdef GOLOMB_RICE_DECODE_ERR_EN
              w_err_entry  = 1'b1;
              w_done_entry = 1'b1;
              state_d      = S_DONE;
`else
              q_d = q_q;
`endif
            end else begin
              q_d = q_q + 5'd1;
            end
          end else if (k_q != 3'd0) begin
            cnt_d   = k_q;
            state_d = S_SUFFIX;
          end else if (ac_q) begin
            state_d = S_SIGN;
          end else begin
            w_done_entry = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_SUFFIX: begin
        if (w_xfer) begin
          rem_d = {rem_q[5:0], bus.bit_in};
          len_d = len_q + VAL_W'(1);
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (ac_q) begin
              state_d = S_SIGN;
            end else begin
              w_done_entry = 1'b1;
              state_d      = S_DONE;
            end
          end
        end
      end
      S_SIGN: begin
        if (w_xfer) begin
          len_d        = len_q + VAL_W'(1);
          w_sign_bit   = bus.bit_in;
          w_done_entry = 1'b1;
          state_d      = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Results are captured on the final transfer so they are stable during DONE.
    if (w_done_entry) begin
      val_d             = w_err_entry ? '0 : ((VAL_W'(q_d) << k_q) | VAL_W'(rem_d));
      codeword_length_d = len_d;
      is_minus_n_d      = w_sign_bit;
      decode_err_d      = w_err_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      k_q               <= '0;
      ac_q              <= 1'b0;
      q_q               <= '0;
      rem_q             <= '0;
      cnt_q             <= '0;
      len_q             <= '0;
      val_q             <= '0;
      codeword_length_q <= '0;
      is_minus_n_q      <= 1'b0;
      decode_err_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      k_q               <= k_d;
      ac_q              <= ac_d;
      q_q               <= q_d;
      rem_q             <= rem_d;
      cnt_q             <= cnt_d;
      len_q             <= len_d;
      val_q             <= val_d;
      codeword_length_q <= codeword_length_d;
      is_minus_n_q      <= is_minus_n_d;
      decode_err_q      <= decode_err_d;
    end
  end

  assign bus.bit_ready       = w_busy;
  assign bus.busy            = w_busy;
  assign bus.output_valid    = (state_q == S_DONE);
  assign bus.val             = val_q;
  assign bus.is_minus_n      = is_minus_n_q;
  assign bus.codeword_length = codeword_length_q;
`ifdef GOLOMB_RICE_DECODE_ERR_EN
  assign bus.decode_err      = decode_err_q;
`else
  logic w_unused;
  assign w_unused = decode_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_golomb_rice_decode.sv
// +--------------------------------------------------------------------------+
// | tb_golomb_rice_decode : directed self-checking bench, MAX_Q = 3           |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_golomb_rice_decode;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  golomb_rice_decode_if #(.VAL_W(32)) bus ();

  golomb_rice_decode #(
    .MAX_Q (3),
    .VAL_W (32)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] v,
                              input logic [31:0] len, input logic minus);
    check({tag, "_valid"}, 32'(bus.output_valid), 32'd1);
    check({tag, "_val"},   bus.val, v);
    check({tag, "_len"},   bus.codeword_length, len);
    check({tag, "_minus"}, 32'(bus.is_minus_n), 32'(minus));
  endtask

  // Called at a negedge; leaves start low one cycle later with the FSM in PREFIX.
  task automatic do_start(input logic [2:0] kk, input logic ac);
    bus.start       = 1'b1;
    bus.k           = kk;
    bus.is_ac_level = ac;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Sends n bits MSB first; optional idle cycle between bits but not after the last.
  task automatic send(input logic [15:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      bus.bit_in    = bits[i];
      bus.bit_valid = 1'b1;
      @(negedge clk);
      bus.bit_valid = 1'b0;
      if (gap && i != 0) @(negedge clk);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.k           = 3'd0;
    bus.is_ac_level = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_ready", 32'(bus.bit_ready), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.output_valid), 32'd0);
    check("rst_val",   bus.val, 32'd0);
    check("rst_len",   bus.codeword_length, 32'd0);
    check("rst_minus", 32'(bus.is_minus_n), 32'd0);

    // A stray bit outside a codeword must be ignored.
    send(16'b1, 1, 1'b0);
    check("stray_busy", 32'(bus.busy), 32'd0);

    // k=0, plain: 0001 -> 3, length 4
    do_start(3'd0, 1'b0);
    check("t1_busy",  32'(bus.busy), 32'd1);
    check("t1_ready", 32'(bus.bit_ready), 32'd1);
    send(16'b0001, 4, 1'b0);
    check_result("t1", 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    check("t1_pulse", 32'(bus.output_valid), 32'd0);
    check("t1_idle",  32'(bus.busy), 32'd0);
    check("t1_hold",  bus.val, 32'd3);

    // k=2, plain: 000 1 01 -> (3<<2)|1 = 13, length 6
    do_start(3'd2, 1'b0);
    send(16'b000101, 6, 1'b0);
    check_result("t2", 32'd13, 32'd6, 1'b0);
    @(negedge clk);

    // k=1, AC: 00 1 1 1 -> (2<<1)|1 = 5, negative, length 5
    do_start(3'd1, 1'b1);
    send(16'b00111, 5, 1'b0);
    check_result("t3n", 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    do_start(3'd1, 1'b1);
    send(16'b00110, 5, 1'b0);
    check_result("t3p", 32'd5, 32'd5, 1'b0);
    @(negedge clk);

    // Back-to-back: start held during DONE, second codeword "1" at k=0
    do_start(3'd1, 1'b1);
    send(16'b00111, 5, 1'b0);
    check_result("b2b_a", 32'd5, 32'd5, 1'b1);
    do_start(3'd0, 1'b0);
    check("b2b_noidle", 32'(bus.busy), 32'd1);
    check("b2b_pulse",  32'(bus.output_valid), 32'd0);
    send(16'b1, 1, 1'b0);
    check_result("b2b_b", 32'd0, 32'd1, 1'b0);
    @(negedge clk);

    // Stalling bit_valid every other cycle gives identical results
    do_start(3'd2, 1'b0);
    send(16'b000101, 6, 1'b1);
    check_result("gap", 32'd13, 32'd6, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-prefix discards the codeword
    do_start(3'd0, 1'b0);
    send(16'b00, 2, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_val",   bus.val, 32'd0);
    check("mrst_len",   bus.codeword_length, 32'd0);
    check("mrst_busy",  32'(bus.busy), 32'd0);
    check("mrst_ready", 32'(bus.bit_ready), 32'd0);
    check("mrst_valid", 32'(bus.output_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_novalid", 32'(bus.output_valid), 32'd0);
    do_start(3'd0, 1'b0);
    send(16'b1, 1, 1'b0);
    check_result("mrst_fresh", 32'd0, 32'd1, 1'b0);
    @(negedge clk);

    // Prefix overflow with MAX_Q = 3: 00000 1
    do_start(3'd0, 1'b0);
`ifdef GOLOMB_RICE_DECODE_ERR_EN
    send(16'b0000, 4, 1'b0);
    check_result("ovf", 32'd0, 32'd4, 1'b0);
    check("ovf_err", 32'(bus.decode_err), 32'd1);
    send(16'b01, 2, 1'b0);
    check("ovf_drop", 32'(bus.busy), 32'd0);
    do_start(3'd0, 1'b0);
    check("err_clear", 32'(bus.decode_err), 32'd0);
    send(16'b01, 2, 1'b0);
    check_result("post_err", 32'd1, 32'd2, 1'b0);
    check("post_err_flag", 32'(bus.decode_err), 32'd0);
`else
    send(16'b000001, 6, 1'b0);
    check_result("ovf", 32'd3, 32'd6, 1'b0);
`endif
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
